// File: rtl/counter_ctrl.sv
// Command sequencer for the 8-bit loadable up-counter: load, count to end, repeat, pulse done.
// Optional one-entry pending-command register enabled by COUNTER_CTRL_CMD_QUEUE_EN.
module counter_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned REP_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_start,
  input  logic [WIDTH-1:0] cmd_end,
  input  logic [REP_W-1:0] cmd_reps,
  input  logic             abort,
  output logic [WIDTH-1:0] cnt_data,
  output logic             cnt_load,
  output logic             cnt_enable,
  input  logic [WIDTH-1:0] cnt_q,
  output logic             busy,
  output logic             done,
  output logic [REP_W-1:0] reps_left
);

  typedef enum logic [1:0] {IDLE, LOAD, COUNT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] start_r;
  logic [WIDTH-1:0] end_r;
  logic             accept;
  logic             at_end;

`ifdef COUNTER_CTRL_CMD_QUEUE_EN
  logic             pend_valid;
  logic [WIDTH-1:0] pend_start;
  logic [WIDTH-1:0] pend_end;
  logic [REP_W-1:0] pend_reps;

  assign cmd_ready = ~reset & ~pend_valid;
`else
  assign cmd_ready = ~reset & (state == IDLE);
`endif

  assign accept     = cmd_valid & cmd_ready;
  assign at_end     = (cnt_q == end_r);
  assign cnt_data   = start_r;
  assign cnt_load   = (state == LOAD) & ~abort;
  assign cnt_enable = (state == COUNT) & ~at_end & ~abort;
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);

  // Sequencer state and the active command registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      start_r   <= '0;
      end_r     <= '0;
      reps_left <= '0;
`ifdef COUNTER_CTRL_CMD_QUEUE_EN
      pend_valid <= 1'b0;
      pend_start <= '0;
      pend_end   <= '0;
      pend_reps  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
`ifdef COUNTER_CTRL_CMD_QUEUE_EN
          if (pend_valid) begin
            start_r    <= pend_start;
            end_r      <= pend_end;
            reps_left  <= pend_reps;
            pend_valid <= 1'b0;
            state      <= LOAD;
          end else if (accept) begin
            start_r   <= cmd_start;
            end_r     <= cmd_end;
            reps_left <= cmd_reps;
            state     <= LOAD;
          end
`else
          if (accept) begin
            start_r   <= cmd_start;
            end_r     <= cmd_end;
            reps_left <= cmd_reps;
            state     <= LOAD;
          end
`endif
        end
        LOAD: begin
          if (abort) begin
            reps_left <= '0;
            state     <= IDLE;
          end else begin
            state <= COUNT;
          end
        end
        COUNT: begin
          if (abort) begin
            reps_left <= '0;
            state     <= IDLE;
          end else if (at_end) begin
            if (reps_left == '0) begin
              state <= DONE;
            end else begin
              reps_left <= reps_left - REP_W'(1);
              state     <= LOAD;
            end
          end
        end
        DONE: begin
          reps_left <= '0;
`ifdef COUNTER_CTRL_CMD_QUEUE_EN
          // A waiting command chains straight into LOAD without an IDLE cycle
          if (!abort && pend_valid) begin
            start_r    <= pend_start;
            end_r      <= pend_end;
            reps_left  <= pend_reps;
            pend_valid <= 1'b0;
            state      <= LOAD;
          end else begin
            state <= IDLE;
          end
`else
          state <= IDLE;
`endif
        end
        default: state <= IDLE;
      endcase

`ifdef COUNTER_CTRL_CMD_QUEUE_EN
      // Commands arriving while busy park in the pending slot; abort drops it
      if (state != IDLE) begin
        if (accept) begin
          pend_valid <= 1'b1;
          pend_start <= cmd_start;
          pend_end   <= cmd_end;
          pend_reps  <= cmd_reps;
        end else if (abort) begin
          pend_valid <= 1'b0;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_counter_ctrl.sv
// Randomized scoreboard bench for counter_ctrl with a behavioural counter and per-command timing model.
module tb_counter_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_start = '0;
  logic [7:0] cmd_end = '0;
  logic [3:0] cmd_reps = '0;
  logic       abort = 1'b0;
  logic [7:0] cnt_data;
  logic       cnt_load;
  logic       cnt_enable;
  logic [7:0] q = '0;
  logic       busy;
  logic       done;
  logic [3:0] reps_left;

  counter_ctrl #(.WIDTH(8), .REP_W(4)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_start(cmd_start), .cmd_end(cmd_end), .cmd_reps(cmd_reps), .abort(abort),
    .cnt_data(cnt_data), .cnt_load(cnt_load), .cnt_enable(cnt_enable), .cnt_q(q),
    .busy(busy), .done(done), .reps_left(reps_left)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // The loadable up-counter being sequenced
  always @(posedge clk) begin
    if (cnt_load) q <= cnt_data;
    else if (cnt_enable) q <= q + 8'd1;
  end

  typedef struct {
    int start;
    int end_v;
    int reps;
    int done_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   last_free = 0;
  int   loads = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Cycles for a whole command: every pass is LOAD plus d+1 COUNT cycles
  function automatic int cmd_len(input int s, input int e, input int r);
    return (r + 1) * (((e - s) & 255) + 2);
  endfunction

  task automatic send(input int s, input int e, input int r, output int acc);
    int   n;
    int   st;
    exp_t x;
    n = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_start = 8'(s);
    cmd_end   = 8'(e);
    cmd_reps  = 4'(r);
    #1;
    while (!cmd_ready && n < 2000) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!cmd_ready) begin
      chk("accept_timeout", 0, 1);
      cmd_valid = 1'b0;
      acc = -1;
    end else begin
      acc = cyc + 1;
      st = (acc > last_free) ? acc : last_free;
      x.start = s;
      x.end_v = e;
      x.reps = r;
      x.done_cyc = st + cmd_len(s, e, r);
      last_free = x.done_cyc + 1;
      exp_q.push_back(x);
      @(posedge clk);
      #1 cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      #3;
      n++;
    end while ((exp_q.size() != 0 || busy) && n < 5000);
    if (exp_q.size() != 0 || busy) chk("idle_timeout", 0, 1);
  endtask

  // Monitor: checks every load against the active command and every done against the model
  always begin
    exp_t x;
    @(negedge clk);
    #2;
    if (reset) begin
      loads = 0;
    end else begin
      if (cnt_load) begin
        if (exp_q.size() == 0) chk("load_unexpected", 1, 0);
        else begin
          chk("load_data", int'(cnt_data), exp_q[0].start);
          chk("load_reps_left", int'(reps_left), exp_q[0].reps - loads);
          loads++;
        end
      end
      if (done) begin
        if (exp_q.size() == 0) chk("done_unexpected", 1, 0);
        else begin
          x = exp_q.pop_front();
          chk("done_cycle", cyc, x.done_cyc);
          chk("done_q", int'(q), x.end_v);
          chk("done_passes", loads, x.reps + 1);
        end
        loads = 0;
      end else if (!busy) begin
        loads = 0;
      end
    end
  end

  initial begin
    int a1, a2, s, e, r, k, n;
    #2;
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready", int'(cmd_ready), 0);
    chk("rst_load", int'(cnt_load), 0);
    chk("rst_enable", int'(cnt_enable), 0);
    chk("rst_data", int'(cnt_data), 0);
    chk("rst_done", int'(done), 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rel_ready", int'(cmd_ready), 1);
    chk("rel_reps_left", int'(reps_left), 0);

    send(8'h55, 8'h5A, 0, a1);
    wait_idle();
    chk("hold_q_5a", int'(q), 8'h5A);

    send(8'hFE, 8'h01, 2, a1);
    wait_idle();
    chk("hold_q_01", int'(q), 8'h01);

    send(8'h33, 8'h33, 1, a1);
    wait_idle();

    // Abort mid-run freezes the counter and returns to IDLE without done
    send(8'h55, 8'h5A, 0, a1);
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (q != 8'h57 && n < 50);
    chk("abort_reach_57", int'(q), 8'h57);
    abort = 1'b1;
    void'(exp_q.pop_front());
    last_free = 0;
    #1;
    chk("abort_enable", int'(cnt_enable), 0);
    chk("abort_load", int'(cnt_load), 0);
    @(posedge clk);
    #1 abort = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_ready", int'(cmd_ready), 1);
    chk("abort_reps_left", int'(reps_left), 0);
    chk("abort_q", int'(q), 8'h57);
    chk("abort_done", int'(done), 0);

    // Second command issued while the first is running
    send(8'h20, 8'h24, 0, a1);
    send(8'h10, 8'h12, 0, a2);
`ifdef COUNTER_CTRL_CMD_QUEUE_EN
    chk("b2b_accept", a2, a1 + 1);
`else
    chk("b2b_accept", a2, a1 + 8);
`endif
    wait_idle();
    chk("b2b_q", int'(q), 8'h12);

    // Reset pulse in the middle of COUNT
    send(8'h00, 8'h40, 0, a1);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    void'(exp_q.pop_front());
    last_free = 0;
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_enable", int'(cnt_enable), 0);
    chk("midrst_load", int'(cnt_load), 0);
    chk("midrst_ready", int'(cmd_ready), 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_rel_ready", int'(cmd_ready), 1);
    chk("midrst_rel_reps", int'(reps_left), 0);

    // Random commands, some with a random abort before completion
    for (int i = 0; i < 30; i++) begin
      s = int'($urandom_range(0, 255));
      e = (s + int'($urandom_range(0, 40))) & 255;
      if ($urandom_range(0, 5) == 0) e = int'($urandom_range(0, 255));
      r = int'($urandom_range(0, 3));
      send(s, e, r, a1);
      if ($urandom_range(0, 3) == 0) begin
        k = int'($urandom_range(1, cmd_len(s, e, r) - 1));
        @(negedge clk);
        while (cyc < a1 + k) @(negedge clk);
        abort = 1'b1;
        void'(exp_q.pop_front());
        last_free = 0;
        @(posedge clk);
        #1 abort = 1'b0;
        chk("rnd_abort_busy", int'(busy), 0);
      end else begin
        wait_idle();
        chk("rnd_hold_q", int'(q), e);
      end
    end

    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
